// File: rtl/music_score_player_if.sv
// Control, ROM and tone signals of the score player.
// master = board control logic plus the ROM; slave = the player itself.
interface music_score_player_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int ROM_WIDTH  = 12
);
  logic                  start;
  logic                  stop;
  logic                  loop_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [ROM_WIDTH-1:0]  rom_data;
  logic                  buzzer;
  logic                  playing;
  logic                  done;
  logic [ROM_WIDTH-1:0]  cur_note;

  modport master (
    output start, stop, loop_en, rom_data,
    input  rom_addr, buzzer, playing, done, cur_note
  );

  modport slave (
    input  start, stop, loop_en, rom_data,
    output rom_addr, buzzer, playing, done, cur_note
  );
endinterface

// File: rtl/music_score_player.sv
// Score ROM sequencer: one ROM entry per beat, each decoded into a tone
// half-period that drives a square wave on the buzzer.
module music_score_player #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int ADDR_WIDTH  = 7,
  parameter int ROM_DEPTH   = 128,
  parameter int ROM_WIDTH   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  music_score_player_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;

  localparam int                    NUM_TONES = 21;
  localparam logic [31:0]           BEAT_LAST = 32'(BEAT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ROM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  function automatic int base_freq(input int idx);
    case (idx)
      0:       return 262;
      1:       return 294;
      2:       return 330;
      3:       return 349;
      4:       return 392;
      5:       return 440;
      default: return 494;
    endcase
  endfunction

  // Table index = octave*7 + (note-1); octave 0 = low, 1 = med, 2 = high.
  logic [23:0] half_tbl [NUM_TONES];

  generate
    for (genvar gi = 0; gi < NUM_TONES; gi++) begin : g_tone
      localparam int FREQ = base_freq(gi % 7) << (gi / 7);
      assign half_tbl[gi] = 24'(CLK_FREQ / (2 * FREQ));
    end
  endgenerate

  logic [3:0]  nib_hi;
  logic [3:0]  nib_md;
  logic [3:0]  nib_lo;
  logic [3:0]  sel_nib;
  logic [1:0]  sel_oct;
  logic [4:0]  tone_idx;
  logic [23:0] half_dec;

  always_comb begin
    nib_hi  = bus.rom_data[11:8];
    nib_md  = bus.rom_data[7:4];
    nib_lo  = bus.rom_data[3:0];
    sel_nib = nib_lo;
    sel_oct = 2'd0;
    if (nib_hi != 4'd0) begin
      sel_nib = nib_hi;
      sel_oct = 2'd2;
    end else if (nib_md != 4'd0) begin
      sel_nib = nib_md;
      sel_oct = 2'd1;
    end
    tone_idx = 5'(sel_oct) * 5'd7 + 5'(sel_nib) - 5'd1;
    half_dec = 24'd0;
    // Zero or 8..15 in the selected nibble is a rest.
    if ((sel_nib != 4'd0) && (sel_nib <= 4'd7)) begin
      half_dec = half_tbl[tone_idx];
    end
  end

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  buzz_q, buzz_d;
  logic                  done_q, done_d;
  logic [ROM_WIDTH-1:0]  note_q, note_d;
  logic [23:0]           half_q, half_d;
  logic [31:0]           beat_q, beat_d;
  logic [23:0]           tone_q, tone_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    buzz_d  = buzz_q;
    done_d  = 1'b0;
    note_d  = note_q;
    half_d  = half_q;
    beat_d  = beat_q;
    tone_d  = tone_q;

    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        buzz_d = 1'b0;
        if (bus.start && !bus.stop) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          buzz_d  = 1'b0;
        end else begin
          note_d  = bus.rom_data;
          half_d  = half_dec;
          beat_d  = 32'd0;
          tone_d  = 24'd0;
          buzz_d  = 1'b0;
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          buzz_d  = 1'b0;
          beat_d  = 32'd0;
          tone_d  = 24'd0;
        end else if (beat_q == BEAT_LAST) begin
          // Beat over: any tone cycle in progress is truncated here.
          beat_d = 32'd0;
          tone_d = 24'd0;
          buzz_d = 1'b0;
          if (addr_q < ADDR_LAST) begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = ST_FETCH;
          end else if (bus.loop_en) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end else begin
            addr_d  = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          beat_d = beat_q + 32'd1;
          if (half_q == 24'd0) begin
            tone_d = 24'd0;
            buzz_d = 1'b0;
          end else if (tone_q == half_q - 24'd1) begin
            tone_d = 24'd0;
            buzz_d = ~buzz_q;
          end else begin
            tone_d = tone_q + 24'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
        buzz_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      buzz_q  <= 1'b0;
      done_q  <= 1'b0;
      note_q  <= '0;
      half_q  <= 24'd0;
      beat_q  <= 32'd0;
      tone_q  <= 24'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buzz_q  <= buzz_d;
      done_q  <= done_d;
      note_q  <= note_d;
      half_q  <= half_d;
      beat_q  <= beat_d;
      tone_q  <= tone_d;
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.buzzer   = buzz_q;
  assign bus.playing  = (state_q == ST_FETCH) || (state_q == ST_PLAY);
  assign bus.done     = done_q;
  assign bus.cur_note = note_q;

endmodule
